// File: rtl/fly_round_ctrl.sv
`timescale 1ns/1ps
// Round sequencer for the fly-swat game: picks a target fruit, launches the fly-in
// animation, scores hits and landed flies, and paces rounds with an idle gap.
module fly_round_ctrl #(
  parameter logic [25:0] GAP_CYCLES = 26'd25000000,
  parameter logic [3:0]  MAX_MISSES = 4'd3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       hit,
  input  logic       over,
  output logic       start,
  output logic [1:0] address,
  output logic       round_active,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_LAUNCH, S_FLYING, S_LANDED, S_GAP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  misses_q, misses_d;
  logic [1:0]  address_q, address_d;
  logic [25:0] gap_q, gap_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [3:0]  miss_inc;
  logic        abort;

  assign miss_inc = misses_q + 4'd1;
  // Dropping go mid-game beats any hit or landing seen in the same cycle.
  assign abort    = !go && (state_q inside {S_PICK, S_LAUNCH, S_FLYING, S_LANDED, S_GAP});

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: each always_comb assigns a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = S_PICK;
      S_PICK:   state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_FLYING;
      S_FLYING: begin
        if (hit)       state_d = S_GAP;
        else if (over) state_d = S_LANDED;
      end
      S_LANDED: state_d = (miss_inc == MAX_MISSES) ? S_DONE : S_GAP;
      S_GAP:    if (gap_q == GAP_CYCLES - 26'd1) state_d = S_PICK;
      S_DONE:   if (!go) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    start        = 1'b0;
    round_active = 1'b0;
    game_over    = 1'b0;
    case (state_q)
      S_LAUNCH: start = 1'b1;
      S_FLYING: begin
        start        = 1'b1;
        round_active = 1'b1;
      end
      S_LANDED: start     = 1'b1;
      S_DONE:   game_over = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    score_d   = score_q;
    misses_d  = misses_q;
    address_d = address_q;
    gap_d     = '0;
    // Reseed guard keeps the shift register out of the all-zero lock-up state.
    lfsr_d    = (lfsr_q == 8'd0) ? LFSR_SEED
                                 : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      S_IDLE: if (go) begin
        score_d  = '0;
        misses_d = '0;
      end
      S_PICK:   address_d = lfsr_q[1:0];
      S_FLYING: if (hit && !abort && score_q != 8'hFF) score_d = score_q + 8'd1;
      S_LANDED: if (!abort) misses_d = miss_inc;
      S_GAP:    gap_d = gap_q + 26'd1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      score_q   <= '0;
      misses_q  <= '0;
      address_q <= '0;
      gap_q     <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      score_q   <= score_d;
      misses_q  <= misses_d;
      address_q <= address_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign address = address_q;
  assign score   = score_q;
  assign misses  = misses_q;

endmodule

// File: tb/tb_fly_round_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for fly_round_ctrl: expected end-of-round counts are queued as the
// round-ending stimulus is driven and compared when start falls.
module tb_fly_round_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0, hit = 1'b0, over = 1'b0;
  logic       start, round_active, game_over;
  logic [1:0] address;
  logic [7:0] score;
  logic [3:0] misses;

  fly_round_ctrl #(.GAP_CYCLES(26'd10), .MAX_MISSES(4'd3), .LFSR_SEED(8'hA5)) dut (
    .clock(clock), .reset(reset), .go(go), .hit(hit), .over(over),
    .start(start), .address(address), .round_active(round_active),
    .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, seeded 0xA5 on reset.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  logic [7:0] m_lfsr, m_prev;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  // Monitor: start rising means the address was just latched from the PICK-cycle LFSR;
  // start falling ends a round and retires one scoreboard entry.
  logic prev_start = 1'b0;
  always @(negedge clock) begin
    if (start && !prev_start) check("addr", 32'(address), 32'(m_prev[1:0]));
    if (!start && prev_start) begin
      if (sb_q.size() == 0) check("sb_unexpected_end", 1, 0);
      else begin
        mon_e = sb_q.pop_front();
        check("end_score", 32'(score), 32'(mon_e.score));
        check("end_misses", 32'(misses), 32'(mon_e.misses));
        check("end_game_over", 32'(game_over), 32'(mon_e.game_over));
      end
    end
    prev_start <= start;
  end

  task automatic expect_end(input logic [7:0] s, input logic [3:0] m, input logic g);
    exp_t e;
    e.score = s; e.misses = m; e.game_over = g;
    sb_q.push_back(e);
  endtask

  task automatic wait_start(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (start !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (start !== lvl) check(tag, 32'(start), 32'(lvl));
  endtask

  // Returns at a negedge inside FLYING.
  task automatic next_round();
    wait_start(1'b1, 40, "start_rise_timeout");
    @(negedge clock);
    check("round_active", 32'(round_active), 1);
  endtask

  task automatic do_hit(input logic [7:0] s, input logic [3:0] m);
    hit = 1'b1;
    expect_end(s, m, 1'b0);
    @(negedge clock);
    hit = 1'b0;
  endtask

  task automatic do_miss(input logic [7:0] s, input logic [3:0] m, input logic g);
    over = 1'b1;
    expect_end(s, m, g);
    @(negedge clock);
    over = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_address"}, 32'(address), 0);
    check({tag, "_round_active"}, 32'(round_active), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_misses"}, 32'(misses), 0);
    check({tag, "_game_over"}, 32'(game_over), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low;
    logic [7:0] s;

    #1 reset = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    go = 1'b1;

    // Round 1: hit, then measure the start-low window and poke hit during GAP.
    next_round();
    do_hit(8'd1, 4'd0);
    low = 0;
    while (start == 1'b0 && low < 40) begin
      low++;
      hit = (low == 4);
      @(negedge clock);
    end
    hit = 1'b0;
    check("gap_low_cycles", 32'(low), 11);
    check("hit_in_gap_ignored", 32'(score), 1);

    // Round 2: hit and over together count as a hit only.
    next_round();
    hit = 1'b1; over = 1'b1;
    expect_end(8'd2, 4'd0, 1'b0);
    @(negedge clock);
    hit = 1'b0; over = 1'b0;

    // Three landings end the game.
    next_round(); do_miss(8'd2, 4'd1, 1'b0);
    next_round(); do_miss(8'd2, 4'd2, 1'b0);
    next_round(); do_miss(8'd2, 4'd3, 1'b1);
    repeat (3) @(negedge clock);
    check("done_start", 32'(start), 0);
    check("done_game_over", 32'(game_over), 1);
    check("done_misses", 32'(misses), 3);
    go = 1'b0;
    @(negedge clock);
    check("idle_game_over", 32'(game_over), 0);
    check("idle_score_hold", 32'(score), 2);
    check("idle_misses_hold", 32'(misses), 3);
    go = 1'b1;
    @(negedge clock);
    check("restart_score", 32'(score), 0);
    check("restart_misses", 32'(misses), 0);

    // Abort during FLYING: simultaneous hit must not count.
    next_round();
    do_hit(8'd1, 4'd0);
    next_round();
    go = 1'b0; hit = 1'b1;
    expect_end(8'd1, 4'd0, 1'b0);
    @(negedge clock);
    hit = 1'b0;
    check("abort_round_active", 32'(round_active), 0);
    @(negedge clock);
    check("abort_start", 32'(start), 0);
    check("abort_score", 32'(score), 1);

    // Reset mid-GAP.
    go = 1'b1;
    @(negedge clock);
    next_round();
    do_hit(8'd1, 4'd0);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero("gap_reset");
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-flight with hit and over pending.
    next_round();
    hit = 1'b1; over = 1'b1;
    expect_end(8'd0, 4'd0, 1'b0);
    #2 reset = 1'b1;
    #1 check("flight_reset_start", 32'(start), 0);
    @(negedge clock);
    reset = 1'b0; hit = 1'b0; over = 1'b0;

    // Score saturation.
    for (int i = 1; i <= 257; i++) begin
      s = (i > 255) ? 8'd255 : 8'(i);
      next_round();
      do_hit(s, 4'd0);
    end
    check("score_saturated", 32'(score), 255);

    go = 1'b0;
    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
